// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store unit: turns an ALU effective address into a
// word-wide memory handshake and returns aligned, extended load data.
module lsu_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     is_store,
    input  logic [2:0]               funct3,
    input  logic [DATA_WIDTH-1:0]    addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [ADDRESS_WIDTH-1:0] rd,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_addr,
    output logic [3:0]               mem_wstrb,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     busy,
    output logic                     done,
    output logic                     fault,
    output logic                     wb_en,
    output logic [ADDRESS_WIDTH-1:0] wb_rd,
    output logic [DATA_WIDTH-1:0]    wb_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t                   r_state;
    logic                     r_is_store;
    logic [2:0]               r_funct3;
    logic [1:0]               r_addr_lo;
    logic [ADDRESS_WIDTH-1:0] r_rd;
    logic                     r_mem_req;
    logic                     r_mem_we;
    logic [DATA_WIDTH-1:0]    r_mem_addr;
    logic [3:0]               r_mem_wstrb;
    logic [DATA_WIDTH-1:0]    r_mem_wdata;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_fault;
    logic                     r_wb_en;
    logic [ADDRESS_WIDTH-1:0] r_wb_rd;
    logic [DATA_WIDTH-1:0]    r_wb_data;

    logic                     w_legal;
    logic [3:0]               w_wstrb;
    logic [DATA_WIDTH-1:0]    w_wdata;
    logic [DATA_WIDTH-1:0]    w_load;

    function automatic logic f_legal(input logic st, input logic [2:0] f3,
                                     input logic [1:0] a);
        logic ok;
        ok = 1'b0;
        case (f3)
            3'b000:         ok = 1'b1;
            3'b001:         ok = ~a[0];
            3'b010:         ok = (a == 2'b00);
            3'b100, 3'b101: ok = ~st;
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] f_strb(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] s;
        s = 4'b0000;
        case (f3)
            3'b000:  s = 4'b0001 << a;
            3'b001:  s = a[1] ? 4'b1100 : 4'b0011;
            3'b010:  s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] f_lanes(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        case (f3)
            3'b000:  r = {4{d[7:0]}};
            3'b001:  r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'b00:   b = d[7:0];
            2'b01:   b = d[15:8];
            2'b10:   b = d[23:16];
            default: b = d[31:24];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = d;
        endcase
        return r;
    endfunction

    assign w_legal = f_legal(is_store, funct3, addr[1:0]);
    assign w_wstrb = f_strb(funct3, addr[1:0]);
    assign w_wdata = f_lanes(funct3, wdata);
    assign w_load  = f_load(r_funct3, r_addr_lo, mem_rdata);

    // Access sequencer; every output is a register so reset clears them asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_is_store  <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr_lo   <= 2'b00;
            r_rd        <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wstrb <= 4'b0000;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            r_wb_en     <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
        end else begin
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            r_wb_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_store <= is_store;
                        r_funct3   <= funct3;
                        r_addr_lo  <= addr[1:0];
                        r_rd       <= rd;
                        r_busy     <= 1'b1;
                        if (w_legal) begin
                            r_state     <= S_REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= is_store;
                            r_mem_addr  <= {addr[DATA_WIDTH-1:2], 2'b00};
                            r_mem_wstrb <= is_store ? w_wstrb : 4'b0000;
                            r_mem_wdata <= w_wdata;
                        end else begin
                            r_state <= S_ERR;
                            r_done  <= 1'b1;
                            r_fault <= 1'b1;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_state     <= S_DONE;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_wstrb <= 4'b0000;
                        r_done      <= 1'b1;
                        if (!r_is_store) begin
                            r_wb_data <= w_load;
                            r_wb_rd   <= r_rd;
                            r_wb_en   <= (r_rd != '0);
                        end else begin
                            r_wb_en   <= 1'b0;
                        end
                    end else begin
                        r_state <= S_REQ;
                    end
                end
                S_DONE, S_ERR: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wstrb = r_mem_wstrb;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign fault     = r_fault;
    assign wb_en     = r_wb_en;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: hand-computed expectations checked with
// immediate assertions one cycle step at a time.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_errors = 0;

    lsu_ctrl #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rd(rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .busy(busy), .done(done), .fault(fault),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [4:0] r, input logic [31:0] rdat,
                            input logic [31:0] exp_data, input logic exp_wb);
        start = 1'b1; is_store = 1'b0; funct3 = f3; addr = a; rd = r;
        tick();
        start = 1'b0;
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_rdata = rdat;
        tick();
        mem_ack = 1'b0;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_wb_en"}, {31'd0, wb_en}, {31'd0, exp_wb});
        if (exp_wb) begin
            chk({tag, "_wb_data"}, wb_data, exp_data);
            chk({tag, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, r});
        end else begin
            chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
        end
        tick();
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    task automatic run_illegal(input string tag, input logic st, input logic [2:0] f3,
                               input logic [31:0] a);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; rd = 5'd7;
        tick();
        start = 1'b0;
        chk({tag, "_done_fault"}, {30'd0, done, fault}, 32'd3);
        chk({tag, "_no_req"}, {30'd0, mem_req, wb_en}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        tick();
        chk({tag, "_after"}, {28'd0, busy, done, fault, mem_req}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'd0; wdata = 32'd0; rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        tick();
        chk("rst_ctrl", {26'd0, mem_req, mem_we, busy, done, fault, wb_en}, 32'd0);
        chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wb", wb_data | {27'd0, wb_rd}, 32'd0);
        rst_n = 1'b1;
        tick();

        // LW, ack in first REQ cycle
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h100; rd = 5'd5;
        tick();
        start = 1'b0;
        chk("lw_req", {29'd0, mem_req, busy, mem_we}, 32'd6);
        chk("lw_addr", mem_addr, 32'h100);
        chk("lw_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("lw_done_early", {31'd0, done}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0;
        chk("lw_done", {29'd0, done, wb_en, busy}, 32'd7);
        chk("lw_wb_rd", {27'd0, wb_rd}, 32'd5);
        chk("lw_wb_data", wb_data, 32'hDEADBEEF);
        chk("lw_req_drop", {31'd0, mem_req}, 32'd0);
        tick();
        chk("lw_idle", {29'd0, busy, done, wb_en}, 32'd0);

        // SB with three wait cycles
        start = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 32'h203; wdata = 32'h123456A5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("sb_req", {29'd0, mem_req, mem_we, done}, 32'd6);
            chk("sb_addr", mem_addr, 32'h200);
            chk("sb_wstrb", {28'd0, mem_wstrb}, 32'h8);
            chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
            if (i == 3) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        chk("sb_done", {30'd0, done, wb_en}, 32'd2);
        tick();
        chk("sb_idle", {31'd0, busy}, 32'd0);

        // SH upper half and SW lanes
        start = 1'b1; is_store = 1'b1; funct3 = 3'b001; addr = 32'h42; wdata = 32'hCAFE1234;
        tick();
        start = 1'b0;
        chk("sh_wstrb", {28'd0, mem_wstrb}, 32'hC);
        chk("sh_wdata", mem_wdata, 32'h12341234);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0; tick();
        start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h44; wdata = 32'hCAFE1234;
        tick();
        start = 1'b0;
        chk("sw_wstrb", {28'd0, mem_wstrb}, 32'hF);
        chk("sw_wdata", mem_wdata, 32'hCAFE1234);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0; tick();

        // Load extraction
        run_load("lh",  3'b001, 32'h2, 5'd1, 32'h80017FFF, 32'hFFFF8001, 1'b1);
        run_load("lhu", 3'b101, 32'h2, 5'd2, 32'h80017FFF, 32'h00008001, 1'b1);
        run_load("lb1", 3'b000, 32'h1, 5'd3, 32'h80017FFF, 32'h0000007F, 1'b1);
        run_load("lb3", 3'b000, 32'h3, 5'd4, 32'h80017FFF, 32'hFFFFFF80, 1'b1);
        run_load("lbu3", 3'b100, 32'h3, 5'd6, 32'h80017FFF, 32'h00000080, 1'b1);
        run_load("lh0", 3'b001, 32'h0, 5'd9, 32'h80017FFF, 32'h00007FFF, 1'b1);

        // Illegal accesses
        run_illegal("lw_mis", 1'b0, 3'b010, 32'h6);
        run_illegal("f3_011", 1'b0, 3'b011, 32'h0);
        run_illegal("sh_mis", 1'b1, 3'b001, 32'h1);
        run_illegal("st_f3_100", 1'b1, 3'b100, 32'h0);

        // rd = 0 suppresses write-back
        run_load("rd0", 3'b010, 32'h10, 5'd0, 32'h11111111, 32'h11111111, 1'b0);

        // start during REQ is ignored
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h300; rd = 5'd8;
        tick();
        addr = 32'h400;
        tick();
        start = 1'b0;
        chk("ign_addr", mem_addr, 32'h300);
        chk("ign_req", {30'd0, mem_req, done}, 32'd2);
        mem_ack = 1'b1; mem_rdata = 32'h0000ABCD;
        tick();
        mem_ack = 1'b0;
        chk("ign_done", {31'd0, done}, 32'd1);
        chk("ign_data", wb_data, 32'h0000ABCD);
        tick();
        chk("ign_one_done_a", {30'd0, done, busy}, 32'd0);
        tick();
        chk("ign_one_done_b", {30'd0, done, busy}, 32'd0);

        // Reset in the middle of a request
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h500; rd = 5'd10;
        tick();
        start = 1'b0;
        chk("abort_req", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_async", {30'd0, mem_req, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        tick();
        mem_ack = 1'b0;
        chk("abort_ack_ign", {28'd0, done, wb_en, busy, mem_req}, 32'd0);
        tick();
        chk("abort_no_done", {29'd0, done, wb_en, busy}, 32'd0);
        run_load("post_rst", 3'b010, 32'h10, 5'd3, 32'h00000055, 32'h00000055, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
